// File: rtl/lock_attempt_controller.sv
// lock_attempt_controller
//   Sequences strobe-qualified password attempts for the digital lock.
//   It counts consecutive failures. After MAX_TRIES failures it holds a timed
//   lockout. After a successful unlock it relocks automatically once the hold
//   time expires.
//   Optional feature macro: LOCK_PWD_CHANGE_EN. When it is defined, set_pwd in
//   UNLOCKED loads a new code. When it is not defined, the code is fixed at
//   CORRECT_PASSWORD.
// Ports
//   clk         : single clock, all logic on posedge
//   reset       : synchronous, active-high
//   submit      : one-cycle strobe, evaluate password this cycle
//   password    : 4-bit code from switches
//   try_again   : level, forces relock while UNLOCKED
//   set_pwd     : strobe, load password as the new code (feature build only)
//   led_output  : 1 = unlocked
//   lockout     : 1 = in LOCKOUT, attempts rejected
//   fail_count  : consecutive failed attempts, saturating at MAX_TRIES
//   attempt_ok  : one-cycle pulse for an accepted attempt
//   attempt_bad : one-cycle pulse for a failed or rejected attempt
module lock_attempt_controller #(
    parameter logic [3:0]  CORRECT_PASSWORD = 4'b1010,
    parameter int unsigned MAX_TRIES        = 3,
    parameter int unsigned LOCKOUT_CYCLES   = 16,
    parameter int unsigned UNLOCK_CYCLES    = 32,
    parameter int unsigned CNT_W            = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       submit,
    input  logic [3:0] password,
    input  logic       try_again,
    input  logic       set_pwd,
    output logic       led_output,
    output logic       lockout,
    output logic [2:0] fail_count,
    output logic       attempt_ok,
    output logic       attempt_bad
);

    localparam int unsigned FAIL_W = 3;
    localparam logic [CNT_W-1:0]  UNLOCK_LOAD  = CNT_W'(UNLOCK_CYCLES - 1);
    localparam logic [CNT_W-1:0]  LOCKOUT_LOAD = CNT_W'(LOCKOUT_CYCLES - 1);
    localparam logic [FAIL_W-1:0] MAX_FAIL     = FAIL_W'(MAX_TRIES);

    typedef enum logic [1:0] {
        ST_LOCKED   = 2'b00,
        ST_UNLOCKED = 2'b01,
        ST_LOCKOUT  = 2'b10
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  timer_q, timer_d;
    logic [FAIL_W-1:0] fail_q, fail_d;
    logic              led_q, led_d;
    logic              lockout_q, lockout_d;
    logic              ok_q, ok_d;
    logic              bad_q, bad_d;
    logic [FAIL_W-1:0] fail_inc;
    logic [3:0]        code;

`ifdef LOCK_PWD_CHANGE_EN
    logic [3:0] code_q, code_d;
    assign code = code_q;
`else
    logic unused_set_pwd;
    assign code           = CORRECT_PASSWORD;
    assign unused_set_pwd = set_pwd;
`endif

    // The failure counter saturates at MAX_TRIES and never wraps.
    assign fail_inc = (fail_q >= MAX_FAIL) ? MAX_FAIL : fail_q + FAIL_W'(1);

    // Register bank: state, timer, counters, code and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_LOCKED;
            timer_q   <= '0;
            fail_q    <= '0;
            led_q     <= 1'b0;
            lockout_q <= 1'b0;
            ok_q      <= 1'b0;
            bad_q     <= 1'b0;
`ifdef LOCK_PWD_CHANGE_EN
            code_q    <= CORRECT_PASSWORD;
`endif
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            fail_q    <= fail_d;
            led_q     <= led_d;
            lockout_q <= lockout_d;
            ok_q      <= ok_d;
            bad_q     <= bad_d;
`ifdef LOCK_PWD_CHANGE_EN
            code_q    <= code_d;
`endif
        end
    end

    // Next-state logic, timer, counter and attempt pulses.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        fail_d  = fail_q;
        ok_d    = 1'b0;
        bad_d   = 1'b0;
`ifdef LOCK_PWD_CHANGE_EN
        code_d  = code_q;
`endif
        case (state_q)
            ST_LOCKED: begin
                // try_again has no effect here. Only submit is evaluated.
                if (submit) begin
                    if (password == code) begin
                        state_d = ST_UNLOCKED;
                        timer_d = UNLOCK_LOAD;
                        fail_d  = '0;
                        ok_d    = 1'b1;
                    end else begin
                        fail_d = fail_inc;
                        bad_d  = 1'b1;
                        if (fail_inc == MAX_FAIL) begin
                            state_d = ST_LOCKOUT;
                            timer_d = LOCKOUT_LOAD;
                        end
                    end
                end
            end
            ST_UNLOCKED: begin
                if (try_again) begin
                    state_d = ST_LOCKED;
`ifdef LOCK_PWD_CHANGE_EN
                end else if (set_pwd) begin
                    // set_pwd takes precedence over submit, so no attempt pulse is raised.
                    code_d  = password;
                    timer_d = UNLOCK_LOAD;
`endif
                end else if (submit) begin
                    if (password == code) begin
                        timer_d = UNLOCK_LOAD;
                        ok_d    = 1'b1;
                    end else begin
                        state_d = ST_LOCKED;
                        fail_d  = FAIL_W'(1);
                        bad_d   = 1'b1;
                    end
                end else if (timer_q == '0) begin
                    state_d = ST_LOCKED;
                end else begin
                    timer_d = timer_q - CNT_W'(1);
                end
            end
            ST_LOCKOUT: begin
                // Attempts are rejected here and do not disturb the timer.
                if (submit) begin
                    bad_d = 1'b1;
                end
                if (timer_q == '0) begin
                    state_d = ST_LOCKED;
                    fail_d  = '0;
                end else begin
                    timer_d = timer_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_LOCKED;
            end
        endcase
        led_d     = (state_d == ST_UNLOCKED);
        lockout_d = (state_d == ST_LOCKOUT);
    end

    assign led_output  = led_q;
    assign lockout     = lockout_q;
    assign fail_count  = fail_q;
    assign attempt_ok  = ok_q;
    assign attempt_bad = bad_q;

endmodule

// File: tb/tb_lock_attempt_controller.sv
// tb_lock_attempt_controller
//   Runs directed scenarios and then randomized traffic against
//   lock_attempt_controller. A behavioural model counts the cycles remaining in
//   the timed modes. Every cycle, the bench compares all outputs of the design
//   with that model.
module tb_lock_attempt_controller;

    localparam logic [3:0] CORRECT  = 4'b1010;
    localparam int         MAX_T    = 3;
    localparam int         LOCK_CYC = 16;
    localparam int         UNL_CYC  = 32;
`ifdef LOCK_PWD_CHANGE_EN
    localparam bit PWD_EN = 1'b1;
`else
    localparam bit PWD_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset, submit, try_again, set_pwd;
    logic [3:0] password;
    logic       led_output, lockout, attempt_ok, attempt_bad;
    logic [2:0] fail_count;

    int n_checks = 0;
    int n_fails  = 0;

    // Model state. The "rem" field holds the number of cycles left in the current
    // timed mode, and that count includes the present cycle.
    bit       m_led, m_lock, m_ok, m_bad;
    int       m_fail, m_rem;
    logic [3:0] m_code;

    lock_attempt_controller dut (
        .clk         (clk),
        .reset       (reset),
        .submit      (submit),
        .password    (password),
        .try_again   (try_again),
        .set_pwd     (set_pwd),
        .led_output  (led_output),
        .lockout     (lockout),
        .fail_count  (fail_count),
        .attempt_ok  (attempt_ok),
        .attempt_bad (attempt_bad)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input bit rst, input bit sub, input logic [3:0] pwd,
                              input bit ta, input bit sp);
        m_ok  = 1'b0;
        m_bad = 1'b0;
        if (rst) begin
            m_led = 0; m_lock = 0; m_fail = 0; m_rem = 0; m_code = CORRECT;
        end else if (m_lock) begin
            if (sub) m_bad = 1'b1;
            m_rem--;
            if (m_rem == 0) begin
                m_lock = 1'b0;
                m_fail = 0;
            end
        end else if (m_led) begin
            if (ta) begin
                m_led = 1'b0;
            end else if (PWD_EN && sp) begin
                m_code = pwd;
                m_rem  = UNL_CYC;
            end else if (sub) begin
                if (pwd == m_code) begin
                    m_rem = UNL_CYC;
                    m_ok  = 1'b1;
                end else begin
                    m_led  = 1'b0;
                    m_fail = 1;
                    m_bad  = 1'b1;
                end
            end else begin
                m_rem--;
                if (m_rem == 0) m_led = 1'b0;
            end
        end else if (sub) begin
            if (pwd == m_code) begin
                m_led  = 1'b1;
                m_rem  = UNL_CYC;
                m_fail = 0;
                m_ok   = 1'b1;
            end else begin
                m_bad = 1'b1;
                if (m_fail < MAX_T) m_fail++;
                if (m_fail == MAX_T) begin
                    m_lock = 1'b1;
                    m_rem  = LOCK_CYC;
                end
            end
        end
    endtask

    // Drive one cycle of inputs, advance the model and compare all outputs.
    task automatic do_cycle(input bit rst, input bit sub, input logic [3:0] pwd,
                            input bit ta, input bit sp);
        @(negedge clk);
        reset = rst; submit = sub; password = pwd; try_again = ta; set_pwd = sp;
        @(posedge clk);
        model_step(rst, sub, pwd, ta, sp);
        #1;
        check_eq("led_output",  32'(led_output),  32'(m_led));
        check_eq("lockout",     32'(lockout),     32'(m_lock));
        check_eq("fail_count",  32'(fail_count),  32'(m_fail));
        check_eq("attempt_ok",  32'(attempt_ok),  32'(m_ok));
        check_eq("attempt_bad", 32'(attempt_bad), 32'(m_bad));
    endtask

    task automatic idle();
        do_cycle(1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
    endtask

    task automatic try_pwd(input logic [3:0] pwd);
        do_cycle(1'b0, 1'b1, pwd, 1'b0, 1'b0);
    endtask

    initial begin
        int cnt;
        reset = 1'b1; submit = 1'b0; password = 4'h0; try_again = 1'b0; set_pwd = 1'b0;
        m_led = 0; m_lock = 0; m_ok = 0; m_bad = 0; m_fail = 0; m_rem = 0; m_code = CORRECT;

        // Reset state
        do_cycle(1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
        do_cycle(1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
        check_eq("rst_led", 32'(led_output), 32'd0);

        // Correct code unlocks on the next cycle, then the hold time relocks
        try_pwd(4'b1010);
        check_eq("unlock_led", 32'(led_output), 32'd1);
        check_eq("unlock_ok",  32'(attempt_ok), 32'd1);
        cnt = 1;
        for (int i = 0; i < 64 && led_output; i++) begin
            idle();
            if (led_output) cnt++;
        end
        check_eq("unlock_hold_cycles", 32'(cnt), 32'(UNL_CYC));

        // Three failures cause lockout, and lockout rejects the correct code
        try_pwd(4'b0000);
        try_pwd(4'b0000);
        try_pwd(4'b0000);
        check_eq("lock_fail3", 32'(fail_count), 32'd3);
        check_eq("lock_on",    32'(lockout),    32'd1);
        cnt = 1;
        try_pwd(4'b1010);
        check_eq("lock_reject_bad", 32'(attempt_bad), 32'd1);
        check_eq("lock_reject_led", 32'(led_output),  32'd0);
        if (lockout) cnt++;
        for (int i = 0; i < 64 && lockout; i++) begin
            idle();
            if (lockout) cnt++;
        end
        check_eq("lockout_cycles", 32'(cnt), 32'(LOCK_CYC));
        check_eq("lock_exit_fail", 32'(fail_count), 32'd0);
        try_pwd(4'b1010);
        check_eq("post_lock_unlock", 32'(led_output), 32'd1);

        // try_again forces an immediate relock
        do_cycle(1'b0, 1'b0, 4'h0, 1'b1, 1'b0);
        check_eq("try_again_led", 32'(led_output), 32'd0);

        // A success clears the failure count, and two later failures leave the lock open to attempts
        try_pwd(4'b0001);
        try_pwd(4'b0010);
        try_pwd(4'b1010);
        check_eq("clear_fail", 32'(fail_count), 32'd0);
        do_cycle(1'b0, 1'b0, 4'h0, 1'b1, 1'b0);
        try_pwd(4'b0001);
        try_pwd(4'b0001);
        check_eq("two_fail_cnt",  32'(fail_count), 32'd2);
        check_eq("two_fail_lock", 32'(lockout),    32'd0);

        // Reset in the middle of a lockout
        try_pwd(4'b0001);
        idle();
        do_cycle(1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
        check_eq("rst_mid_lock", 32'(lockout), 32'd0);

        // Submit together with try_again while LOCKED: the submit is evaluated
        do_cycle(1'b0, 1'b1, 4'b1010, 1'b1, 1'b0);
        check_eq("sub_ta_locked", 32'(led_output), 32'd1);
        do_cycle(1'b0, 1'b0, 4'h0, 1'b1, 1'b0);

`ifdef LOCK_PWD_CHANGE_EN
        // Change the code, relock, then confirm the old code fails and the new code opens
        try_pwd(4'b1010);
        do_cycle(1'b0, 1'b0, 4'b0110, 1'b0, 1'b1);
        do_cycle(1'b0, 1'b0, 4'h0, 1'b1, 1'b0);
        try_pwd(4'b1010);
        check_eq("pwd_old_bad", 32'(attempt_bad), 32'd1);
        try_pwd(4'b0110);
        check_eq("pwd_new_ok", 32'(led_output), 32'd1);
        do_cycle(1'b0, 1'b0, 4'h0, 1'b1, 1'b0);
`endif

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            bit r, s, t, p;
            logic [3:0] pw;
            r  = ($urandom_range(0, 199) == 0);
            s  = ($urandom_range(0, 99) < 35);
            t  = ($urandom_range(0, 99) < 4);
            p  = ($urandom_range(0, 99) < 4);
            pw = ($urandom_range(0, 1) == 1) ? m_code : 4'($urandom);
            do_cycle(r, s, pw, t, p);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
